// File: rtl/lut_state_sequencer.sv
// Switch-state sequencer: qualifies LUT (or override) candidates, hands them
// to the switch driver with a request/ack handshake, then enforces a dwell.
//
// state   | meaning
// IDLE    | waiting for a strobe whose candidate differs from sw_state
// QUALIFY | counting consecutive agreeing candidates
// REQUEST | sw_req high, waiting for sw_ack or ack timeout
// DWELL   | change committed, strobes ignored until dwell counter expires
module lut_state_sequencer #(
  parameter int unsigned CONFIRM_COUNT = 3,
  parameter logic [15:0] DWELL_CYCLES  = 16'd1000,
  parameter logic [7:0]  ACK_TIMEOUT   = 8'd255,
  parameter logic [6:0]  MAX_STATE     = 7'd80,
  parameter logic [6:0]  RESET_STATE   = 7'd80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       n_clk_valid,
  input  logic [6:0] lut_state,
  input  logic       override_en,
  input  logic [6:0] override_state,
  input  logic       sw_ack,
  output logic       sw_req,
  output logic [6:0] sw_target,
  output logic [6:0] sw_state,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_REQUEST = 2'd2,
    ST_DWELL   = 2'd3
  } state_t;

  localparam logic [7:0] LP_CONFIRM = (CONFIRM_COUNT > 32'd255) ? 8'd255 : 8'(CONFIRM_COUNT);
  localparam logic       LP_SINGLE  = (CONFIRM_COUNT <= 32'd1);

  state_t      r_state;
  logic        r_strobe;
  logic [6:0]  r_cand;
  logic [7:0]  r_count;
  logic [7:0]  r_ack_timer;
  logic [15:0] r_dwell;
  logic        r_sw_req;
  logic [6:0]  r_sw_target;
  logic [6:0]  r_sw_state;
  logic        r_fault;

  logic [6:0]  w_cand_raw;
  logic [6:0]  w_cand;
  logic        w_differs;
  logic        w_enter_req;
  state_t      w_nxt_state;
  logic [6:0]  w_nxt_cand;
  logic [7:0]  w_nxt_count;
  logic [7:0]  w_nxt_ack_timer;
  logic [15:0] w_nxt_dwell;
  logic        w_nxt_sw_req;
  logic [6:0]  w_nxt_sw_target;
  logic [6:0]  w_nxt_sw_state;
  logic        w_nxt_fault;

  assign w_cand_raw = override_en ? override_state : lut_state;
  assign w_cand     = (w_cand_raw > MAX_STATE) ? MAX_STATE : w_cand_raw;
  assign w_differs  = (w_cand != r_sw_state);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cand      = r_cand;
    w_nxt_count     = r_count;
    w_nxt_ack_timer = r_ack_timer;
    w_nxt_dwell     = r_dwell;
    w_nxt_sw_req    = r_sw_req;
    w_nxt_sw_target = r_sw_target;
    w_nxt_sw_state  = r_sw_state;
    w_nxt_fault     = r_fault;
    w_enter_req     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_strobe && w_differs) begin
          w_nxt_cand  = w_cand;
          w_nxt_count = 8'd1;
          if (override_en || LP_SINGLE) begin
            w_enter_req = 1'b1;
          end else begin
            w_nxt_state = ST_QUALIFY;
          end
        end
      end

      ST_QUALIFY: begin
        if (r_strobe) begin
          if (!w_differs) begin
            w_nxt_state = ST_IDLE;
            w_nxt_count = 8'd0;
          end else if (override_en) begin
            // override skips the remaining qualification
            w_nxt_cand  = w_cand;
            w_nxt_count = 8'd1;
            w_enter_req = 1'b1;
          end else if (w_cand == r_cand) begin
            w_nxt_count = r_count + 8'd1;
            if ((r_count + 8'd1) >= LP_CONFIRM) begin
              w_enter_req = 1'b1;
            end
          end else begin
            w_nxt_cand  = w_cand;
            w_nxt_count = 8'd1;
          end
        end
      end

      ST_REQUEST: begin
        // ack is checked first so a coincident strobe is simply dropped
        if (sw_ack && r_sw_req) begin
          w_nxt_sw_state = r_sw_target;
          w_nxt_sw_req   = 1'b0;
          w_nxt_dwell    = DWELL_CYCLES;
          w_nxt_count    = 8'd0;
          w_nxt_state    = ST_DWELL;
        end else if (r_ack_timer <= 8'd1) begin
          w_nxt_sw_req    = 1'b0;
          w_nxt_fault     = 1'b1;
          w_nxt_count     = 8'd0;
          w_nxt_ack_timer = 8'd0;
          w_nxt_state     = ST_IDLE;
        end else begin
          w_nxt_ack_timer = r_ack_timer - 8'd1;
        end
      end

      ST_DWELL: begin
        if (r_dwell <= 16'd1) begin
          w_nxt_dwell = 16'd0;
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_dwell = r_dwell - 16'd1;
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (w_enter_req) begin
      w_nxt_state     = ST_REQUEST;
      w_nxt_sw_req    = 1'b1;
      w_nxt_sw_target = w_cand;
      w_nxt_ack_timer = ACK_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_strobe    <= 1'b0;
      r_cand      <= RESET_STATE;
      r_count     <= 8'd0;
      r_ack_timer <= 8'd0;
      r_dwell     <= 16'd0;
      r_sw_req    <= 1'b0;
      r_sw_target <= RESET_STATE;
      r_sw_state  <= RESET_STATE;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_strobe    <= n_clk_valid;
      r_cand      <= w_nxt_cand;
      r_count     <= w_nxt_count;
      r_ack_timer <= w_nxt_ack_timer;
      r_dwell     <= w_nxt_dwell;
      r_sw_req    <= w_nxt_sw_req;
      r_sw_target <= w_nxt_sw_target;
      r_sw_state  <= w_nxt_sw_state;
      r_fault     <= w_nxt_fault;
    end
  end

  assign sw_req    = r_sw_req;
  assign sw_target = r_sw_target;
  assign sw_state  = r_sw_state;
  assign busy      = (r_state != ST_IDLE);
  assign fault     = r_fault;

endmodule

// File: tb/tb_lut_state_sequencer.sv
// Directed + randomized bench for lut_state_sequencer; expectations come from
// the sequencing rules (last-three-samples window, fixed dwell/timeout lengths).
module tb_lut_state_sequencer;

  localparam int MAX_ST   = 80;
  localparam int RST_ST   = 80;
  localparam int DWELL    = 1000;
  localparam int ACK_TO   = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       n_clk_valid;
  logic [6:0] lut_state;
  logic       override_en;
  logic [6:0] override_state;
  logic       sw_ack;
  logic       sw_req;
  logic [6:0] sw_target;
  logic [6:0] sw_state;
  logic       busy;
  logic       fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lut_state_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .n_clk_valid    (n_clk_valid),
    .lut_state      (lut_state),
    .override_en    (override_en),
    .override_state (override_state),
    .sw_ack         (sw_ack),
    .sw_req         (sw_req),
    .sw_target      (sw_target),
    .sw_state       (sw_state),
    .busy           (busy),
    .fault          (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // n_clk_valid pulse, then the LUT value arrives one cycle later
  task automatic strobe(input logic [6:0] v);
    n_clk_valid = 1'b1;
    lut_state   = 7'($urandom_range(0, 127));
    tick();
    n_clk_valid = 1'b0;
    lut_state   = v;
    tick();
  endtask

  task automatic ack();
    sw_ack = 1'b1;
    tick();
    sw_ack = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, n, exp_cycles);
  endtask

  function automatic logic [6:0] clampv(input logic [6:0] v);
    return (int'(v) > MAX_ST) ? 7'(MAX_ST) : v;
  endfunction

  function automatic logic [6:0] pick_other(input logic [6:0] x1, input logic [6:0] x2);
    logic [6:0] r;
    do r = 7'($urandom_range(0, 79)); while (r == x1 || r == x2);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] v, a, b, c, o, t, u, pf, pick, e_tgt;
    logic [6:0] q[$];
    logic [6:0] cur;
    logic       req_seen, fired, exp_req;
    int         n;

    rst_n = 1'b0; n_clk_valid = 1'b0; lut_state = 7'd0;
    override_en = 1'b0; override_state = 7'd0; sw_ack = 1'b0;
    repeat (3) tick();
    chk("rst_sw_req", sw_req, 0);
    chk("rst_sw_target", sw_target, RST_ST);
    chk("rst_sw_state", sw_state, RST_ST);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    tick();

    // three agreeing samples -> request, ack, 1000-cycle dwell with ignored strobes
    v = pick_other(7'd80, 7'd80);
    strobe(v);
    chk("q1_busy", busy, 1);
    chk("q1_req", sw_req, 0);
    strobe(v);
    chk("q2_req", sw_req, 0);
    strobe(v);
    chk("q3_req", sw_req, 1);
    chk("q3_target", sw_target, v);
    repeat (5) tick();
    chk("req_hold", sw_req, 1);
    chk("req_target_stable", sw_target, v);
    ack();
    chk("ack_state", sw_state, v);
    chk("ack_req_drop", sw_req, 0);
    chk("ack_busy", busy, 1);
    n = 0; req_seen = 1'b0;
    while (busy && n < 5000) begin
      n_clk_valid = (n < 900 && (n % 7) == 0);
      lut_state   = 7'($urandom_range(0, 127));
      tick();
      n++;
      if (sw_req) req_seen = 1'b1;
    end
    n_clk_valid = 1'b0;
    chk("dwell_len", n, DWELL);
    chk("dwell_no_req", req_seen, 0);
    chk("dwell_state_kept", sw_state, v);
    repeat (3) tick();
    chk("post_dwell_idle", busy, 0);
    a = pick_other(v, 7'd80);
    strobe(a);
    chk("post_dwell_qualify", busy, 1);
    strobe(v);
    chk("qualify_back_idle", busy, 0);

    // disagreeing samples restart the count
    a = pick_other(v, v);
    b = pick_other(v, a);
    strobe(a); strobe(b); strobe(a);
    chk("aba_req", sw_req, 0);
    strobe(a);
    chk("abaa_req", sw_req, 0);
    strobe(a);
    chk("abaaa_req", sw_req, 1);
    chk("abaaa_target", sw_target, a);
    ack();
    chk("abaaa_state", sw_state, a);
    wait_idle("abaaa_dwell", DWELL);

    // override above MAX_STATE clamps and skips qualification
    override_en = 1'b1;
    override_state = 7'($urandom_range(81, 127));
    strobe(pick_other(7'd80, 7'd80));
    chk("ovr_req", sw_req, 1);
    chk("ovr_target", sw_target, MAX_ST);
    override_en = 1'b0;
    repeat (4) tick();
    chk("ovr_release_no_abort", sw_req, 1);
    ack();
    chk("ovr_state", sw_state, MAX_ST);
    wait_idle("ovr_dwell", DWELL);

    // override asserted mid-qualification, then strobe coincident with ack
    c = pick_other(7'd80, 7'd80);
    o = pick_other(c, 7'd80);
    strobe(c);
    chk("mid_ovr_qualify", busy, 1);
    chk("mid_ovr_noreq", sw_req, 0);
    override_en = 1'b1;
    override_state = o;
    strobe(c);
    chk("mid_ovr_req", sw_req, 1);
    chk("mid_ovr_target", sw_target, o);
    override_en = 1'b0;
    n_clk_valid = 1'b1;
    tick();
    n_clk_valid = 1'b0;
    lut_state = pick_other(o, c);
    sw_ack = 1'b1;
    tick();
    sw_ack = 1'b0;
    chk("ack_vs_strobe_state", sw_state, o);
    chk("ack_vs_strobe_req", sw_req, 0);
    wait_idle("ack_vs_strobe_dwell", DWELL);

    // ack timeout
    t = pick_other(o, 7'd80);
    strobe(t); strobe(t); strobe(t);
    chk("to_req", sw_req, 1);
    n = 1;
    while (n < 600) begin
      tick();
      if (!sw_req) break;
      n++;
    end
    chk("to_req_len", n, ACK_TO);
    chk("to_fault", fault, 1);
    chk("to_state_kept", sw_state, o);
    chk("to_idle", busy, 0);
    ack();
    tick();
    chk("stray_ack_state", sw_state, o);
    chk("stray_ack_idle", busy, 0);

    // randomized samples vs. a last-three-samples window model
    cur = o;
    for (int txn = 0; txn < 4; txn++) begin
      q.delete();
      fired = 1'b0;
      a = 7'($urandom_range(0, 127));
      b = 7'($urandom_range(0, 127));
      pf = pick_other(cur, cur);
      for (int s = 0; s < 200 && !fired; s++) begin
        case ($urandom_range(0, 2))
          0: pick = cur;
          1: pick = a;
          default: pick = b;
        endcase
        if (s >= 60) pick = pf;
        strobe(pick);
        q.push_back(clampv(pick));
        if (q.size() > 3) void'(q.pop_front());
        exp_req = (q.size() == 3) && (q[0] == q[1]) && (q[1] == q[2]) && (q[2] != cur);
        chk("rnd_req", sw_req, exp_req);
        if (exp_req) fired = 1'b1;
      end
      chk("rnd_fired", fired, 1);
      if (fired) begin
        e_tgt = q[2];
        chk("rnd_target", sw_target, e_tgt);
        repeat ($urandom_range(0, 5)) tick();
        chk("rnd_req_hold", sw_req, 1);
        ack();
        cur = e_tgt;
        chk("rnd_state", sw_state, cur);
        wait_idle("rnd_dwell", DWELL);
      end
    end
    chk("fault_sticky", fault, 1);

    // reset while requesting: nothing committed, everything back to reset values
    u = pick_other(cur, 7'd80);
    strobe(u); strobe(u); strobe(u);
    chk("rr_req", sw_req, 1);
    rst_n = 1'b0;
    sw_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    sw_ack = 1'b0;
    chk("rr_req_drop", sw_req, 0);
    chk("rr_state", sw_state, RST_ST);
    chk("rr_target", sw_target, RST_ST);
    chk("rr_fault", fault, 0);
    chk("rr_busy", busy, 0);
    tick();
    chk("rr_state_after", sw_state, RST_ST);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lut_state_sequencer.md
LUT_STATE_SEQUENCER -- requirements
Module: lut_state_sequencer

Interface
REQ-001 SHALL have parameters: CONFIRM_COUNT, default 3, consecutive agreeing LUT samples needed before a switch change.
REQ-002 SHALL have parameter DWELL_CYCLES, default 1000 (16-bit), minimum clk cycles between committed changes.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255 (8-bit), maximum cycles to wait for sw_ack.
REQ-004 SHALL have parameter MAX_STATE, default 7'd80, highest legal switch state.
REQ-005 SHALL have parameter RESET_STATE, default 7'd80, committed state after reset.
REQ-006 Port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 Port n_clk_valid, input, 1: one-cycle pulse when a new period count has been presented to the LUT.
REQ-009 Port lut_state, input, 7: registered LUT output, valid the cycle after n_clk_valid.
REQ-010 Port override_en, input, 1: calibration override; selects override_state as candidate.
REQ-011 Port override_state, input, 7: manually requested switch state.
REQ-012 Port sw_ack, input, 1: switch driver has applied sw_target.
REQ-013 Port sw_req, output, 1: request to the switch driver to apply sw_target.
REQ-014 Port sw_target, output, 7: state being requested.
REQ-015 Port sw_state, output, 7: last acknowledged (committed) state.
REQ-016 Port busy, output, 1: high in any FSM state other than IDLE.
REQ-017 Port fault, output, 1: sticky ack-timeout flag.

Function
REQ-018 Sample strobe SHALL be n_clk_valid delayed one cycle; candidate is taken only on strobe cycles.
REQ-019 Candidate SHALL be override_state if override_en else lut_state, clamped to MAX_STATE when greater.
REQ-020 FSM states SHALL be IDLE, QUALIFY, REQUEST, DWELL.
REQ-021 IDLE: on strobe with candidate != sw_state, latch candidate into cand_reg, count=1, go QUALIFY; with override_en, go directly to REQUEST.
REQ-022 QUALIFY: on strobe, candidate == cand_reg increments count; candidate == sw_state returns to IDLE; any other value reloads cand_reg and sets count=1.
REQ-023 QUALIFY SHALL go to REQUEST in the cycle count reaches CONFIRM_COUNT; CONFIRM_COUNT of 1 SHALL go from IDLE straight to REQUEST.
REQ-024 REQUEST: sw_target = cand_reg and sw_req held high until sw_ack; sw_target SHALL stay stable while sw_req is high.
REQ-025 On sw_ack while sw_req is high: sw_state <= sw_target, sw_req deasserted next cycle, dwell counter loaded with DWELL_CYCLES, go DWELL.
REQ-026 A sw_ack with sw_req low SHALL be ignored.
REQ-027 If sw_ack is absent for ACK_TIMEOUT cycles in REQUEST: drop sw_req, set fault, keep sw_state, return to IDLE.
REQ-028 fault SHALL clear only on reset.
REQ-029 DWELL SHALL ignore strobes, decrement each cycle, and return to IDLE when it reaches 0.
REQ-030 DWELL_CYCLES of 0 SHALL return from DWELL to IDLE after one cycle.
REQ-031 Strobe and sw_ack in the same cycle in REQUEST: the ack wins; the strobe is discarded.
REQ-032 Asserting override_en during QUALIFY SHALL replace cand_reg with the override candidate on the next strobe and go to REQUEST.
REQ-033 Deasserting override_en during REQUEST or DWELL SHALL NOT abort the transaction.

Reset
REQ-034 rst_n low at a clock edge SHALL force IDLE, sw_req=0, sw_target=RESET_STATE, sw_state=RESET_STATE, busy=0, fault=0, count=0, dwell counter=0.
REQ-035 Reset during REQUEST SHALL drop sw_req the next cycle without committing sw_target.

Verification
REQ-036 Three strobes with lut_state=40 from sw_state=80 -> sw_req rises the cycle after the third sample, sw_target=40; ack -> sw_state=40, busy until 1000 dwell cycles expire.
REQ-037 Strobes with lut_state 40, 41, 40 -> no sw_req; count restarts at each change.
REQ-038 override_en=1, override_state=100 -> sw_target=80 (clamped) after a single strobe, with no qualification.
REQ-039 In REQUEST, sw_ack held low for 255 cycles -> sw_req=0, fault=1, sw_state unchanged, IDLE.
REQ-040 Strobes during DWELL with differing lut_state -> ignored; a new qualification starts only after returning to IDLE.
REQ-041 rst_n pulsed low while sw_req=1 -> sw_req=0, sw_state=80, fault=0 next cycle.
